adpll_lock_ctrl: RTL and testbench

Acquisition and lock controller for the ADPLL test setup. It sequences start-up of the phase accumulator, ring oscillator and bang-bang phase detector. It drives the ring oscillator frequency-select code from the filtered phase-detector output, first with a coarse binary search and then with fine ±1 tracking, and reports lock. It replaces switch-driven `freq_sel` control.

---
 rtl/adpll_lock_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_adpll_lock_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl: start-up sequencer and frequency-code controller for the ADPLL.
// Coarse binary search on the ring oscillator code, then +/-1 tracking with lock detect.
module adpll_lock_ctrl #(
  parameter int CODE_WIDTH    = 4,
  parameter int WIN_LOG2      = 6,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_COUNT    = 8
) (
  input  logic                  fpga_clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  pd_i,
  output logic [CODE_WIDTH-1:0] code_o,
  output logic                  en_pa_o,
  output logic                  en_ro_o,
  output logic                  en_pd_o,
  output logic                  locked_o,
  output logic                  out_of_range_o,
  output logic [2:0]            state_o
);

  localparam int CW = CODE_WIDTH;
  localparam int WL = WIN_LOG2;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);

  localparam logic [CW-1:0] MID   = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] STEP0 = {2'b01, {(CW-2){1'b0}}};
  localparam logic [WL:0]   HALF  = {2'b01, {(WL-1){1'b0}}};
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_COARSE = 3'd2,
    S_FINE   = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    D_NONE = 2'd0,
    D_UP   = 2'd1,
    D_DN   = 2'd2
  } dir_t;

  logic          r_pd_m;
  logic          r_pd_s;
  state_t        r_state;
  logic [CW-1:0] r_code;
  logic [CW-1:0] r_step;
  logic          r_en;
  logic          r_locked;
  logic          r_oor;
  logic [WL-1:0] r_win;
  logic [WL:0]   r_ones;
  logic [SW-1:0] r_settle;
  dir_t          r_prev;
  logic [LW-1:0] r_lock;

  logic [WL:0]   w_ones;
  logic          w_win_end;
  logic          w_up;
  logic          w_dn;
  logic          w_same;
  logic          w_clip;
  dir_t          w_dir;
  logic [CW-1:0] w_amt;
  logic [CW-1:0] w_code;
  logic [CW:0]   w_sum;
  logic [CW:0]   w_dif;
  logic [LW-1:0] w_lock;

  // Window total includes the sample taken on the closing edge.
  assign w_ones    = r_ones + {{WL{1'b0}}, r_pd_s};
  assign w_win_end = &r_win;
  assign w_up      = w_ones > HALF;
  assign w_dn      = w_ones < HALF;
  assign w_amt     = (r_state == S_COARSE) ? r_step : CW'(1);
  assign w_sum     = {1'b0, r_code} + {1'b0, w_amt};
  assign w_dif     = {1'b0, r_code} - {1'b0, w_amt};

  always_comb begin
    w_dir  = D_NONE;
    w_code = r_code;
    w_clip = 1'b0;
    unique case (1'b1)
      w_up: begin
        w_dir  = D_UP;
        w_code = w_sum[CW] ? '1 : w_sum[CW-1:0];
        w_clip = w_sum[CW];
      end
      w_dn: begin
        w_dir  = D_DN;
        w_code = w_dif[CW] ? '0 : w_dif[CW-1:0];
        w_clip = w_dif[CW];
      end
      default: ;
    endcase
  end

  assign w_same = (w_dir != D_NONE) && (w_dir == r_prev);
  assign w_lock = w_same ? '0 :
                  (r_lock == LOCK_MAX) ? r_lock : r_lock + 1'b1;

  always_ff @(posedge fpga_clk_i) begin
    if (!rst_n_i) begin
      r_pd_m   <= 1'b0;
      r_pd_s   <= 1'b0;
      r_state  <= S_IDLE;
      r_code   <= MID;
      r_step   <= STEP0;
      r_en     <= 1'b0;
      r_locked <= 1'b0;
      r_oor    <= 1'b0;
      r_win    <= '0;
      r_ones   <= '0;
      r_settle <= '0;
      r_prev   <= D_NONE;
      r_lock   <= '0;
    end else begin
      r_pd_m <= pd_i;
      r_pd_s <= r_pd_m;
      if (!start_i) begin
        r_state  <= S_IDLE;
        r_code   <= MID;
        r_step   <= STEP0;
        r_en     <= 1'b0;
        r_locked <= 1'b0;
        r_oor    <= 1'b0;
        r_win    <= '0;
        r_ones   <= '0;
        r_settle <= '0;
        r_prev   <= D_NONE;
        r_lock   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state  <= S_SETTLE;
            r_en     <= 1'b1;
            r_settle <= '0;
          end
          S_SETTLE: begin
            if (r_settle == SET_LAST) begin
              r_state <= S_COARSE;
              r_step  <= STEP0;
              r_win   <= '0;
              r_ones  <= '0;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          S_COARSE, S_FINE, S_LOCKED: begin
            if (w_win_end) begin
              r_win  <= '0;
              r_ones <= '0;
              r_code <= w_code;
              if (w_clip) r_oor <= 1'b1;
              if (r_state == S_COARSE) begin
                if (r_step == CW'(1)) begin
                  r_state <= S_FINE;
                  r_prev  <= D_NONE;
                  r_lock  <= '0;
                end else begin
                  r_step <= r_step >> 1;
                end
              end else if (r_state == S_LOCKED && w_same) begin
                r_state  <= S_FINE;
                r_locked <= 1'b0;
                r_prev   <= D_NONE;
                r_lock   <= '0;
              end else begin
                r_lock <= w_lock;
                if (w_dir != D_NONE) r_prev <= w_dir;
                if (w_lock == LOCK_MAX) begin
                  r_state  <= S_LOCKED;
                  r_locked <= 1'b1;
                end
              end
            end else begin
              r_win  <= r_win + 1'b1;
              r_ones <= w_ones;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign code_o         = r_code;
  assign en_pa_o        = r_en;
  assign en_ro_o        = r_en;
  assign en_pd_o        = r_en;
  assign locked_o       = r_locked;
  assign out_of_range_o = r_oor;
  assign state_o        = r_state;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// tb_adpll_lock_ctrl: directed vector table, abort/reset sequences and random
// PD windows checked against a per-window reference of the lock controller.
module tb_adpll_lock_ctrl;

  localparam int MID  = 8;
  localparam int HALF = 32;
  localparam int WIN  = 64;
  localparam int SET  = 16;
  localparam int MAXW = 24;
  localparam int MAXE = SET + WIN * MAXW + 4;

  typedef enum int {M_UP, M_DN, M_ALT, M_TIE, M_LOSS, M_EDGE, M_RAND} mode_t;

  typedef struct {
    string name;
    mode_t mode;
    int    nwin;
    int    code;
    int    st;
    int    lk;
    int    oor;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pd = 1'b0;
  logic [3:0] code;
  logic       en_pa;
  logic       en_ro;
  logic       en_pd;
  logic       locked;
  logic       oor;
  logic [2:0] st;

  int n_chk = 0;
  int n_pass = 0;

  bit pdv[MAXE];
  int wk[MAXW+2];
  int e_code[MAXW+1];
  int e_st[MAXW+1];
  int e_lk[MAXW+1];
  int e_oor[MAXW+1];

  always #5 clk = ~clk;

  adpll_lock_ctrl dut (
    .fpga_clk_i     (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .pd_i           (pd),
    .code_o         (code),
    .en_pa_o        (en_pa),
    .en_ro_o        (en_ro),
    .en_pd_o        (en_pd),
    .locked_o       (locked),
    .out_of_range_o (oor),
    .state_o        (st)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Window kinds: 0 all ones, 1 all zeros, 2 exact half, 3 half+1, 4 half-1, 5 random bits
  function automatic bit kbit(input int k, input int i);
    case (k)
      0: return 1'b1;
      1: return 1'b0;
      2: return i[0];
      3: return i < 33;
      4: return i < 31;
      default: return bit'($urandom_range(1, 0));
    endcase
  endfunction

  function automatic int kind_of(input mode_t m, input int j);
    case (m)
      M_UP:   return 0;
      M_DN:   return 1;
      M_ALT:  return (j % 2) ? 0 : 1;
      M_TIE:  return 2;
      M_LOSS: return (j > 11) ? 0 : ((j % 2) ? 0 : 1);
      M_EDGE: return (j % 2) ? 3 : 4;
      default: return $urandom_range(5, 0);
    endcase
  endfunction

  // Reference: one decision per window from the count of PD ones it saw.
  task automatic model(input int nwin);
    int cd, step, s, prev, lc, fl, ones, d, tgt;
    bit same;
    cd = MID; step = 4; s = 2; prev = 0; lc = 0; fl = 0;
    e_code[0] = cd; e_st[0] = s; e_lk[0] = 0; e_oor[0] = 0;
    for (int j = 1; j <= nwin; j++) begin
      ones = 0;
      for (int e = SET + WIN * (j - 1) + 1; e <= SET + WIN * j; e++)
        ones += int'(pdv[e - 2]);
      d = (ones > HALF) ? 1 : ((ones < HALF) ? -1 : 0);
      tgt = cd + d * ((s == 2) ? step : 1);
      if (tgt > 15) begin tgt = 15; fl = 1; end
      if (tgt < 0) begin tgt = 0; fl = 1; end
      cd = tgt;
      if (s == 2) begin
        if (step == 1) begin s = 3; prev = 0; lc = 0; end
        else step = step / 2;
      end else begin
        same = (d != 0) && (d == prev);
        lc = same ? 0 : ((lc < 8) ? lc + 1 : 8);
        if (d != 0) prev = d;
        if (same && s == 4) begin s = 3; prev = 0; end
        else if (s == 3 && lc == 8) s = 4;
      end
      e_code[j] = cd; e_st[j] = s;
      e_lk[j] = (s == 4) ? 1 : 0; e_oor[j] = fl;
    end
  endtask

  task automatic run(input string nm, input mode_t m, input int nwin);
    int last, j, i;
    last = SET + WIN * nwin;
    for (int w = 1; w <= nwin; w++) wk[w] = kind_of(m, w);
    for (int e = 0; e <= last; e++) begin
      if (e < 15) pdv[e] = 1'b0;
      else begin
        j = (e - 15) / WIN + 1;
        i = (e - 15) % WIN;
        pdv[e] = (j <= nwin) ? kbit(wk[j], i) : 1'b0;
      end
    end
    model(nwin);
    start = 1'b1;
    for (int e = 0; e <= last; e++) begin
      pd = pdv[e];
      @(negedge clk);
      if (e == 0) begin
        chk({nm, "_settle_state"}, st, 1);
        chk({nm, "_settle_en"}, {en_pa, en_ro, en_pd}, 7);
      end
      if (e == SET - 1) chk({nm, "_settle_last"}, st, 1);
      if (e >= SET && (e - SET) % WIN == 0) begin
        j = (e - SET) / WIN;
        chk($sformatf("%s_w%0d_code", nm, j), code, e_code[j]);
        chk($sformatf("%s_w%0d_state", nm, j), st, e_st[j]);
        chk($sformatf("%s_w%0d_locked", nm, j), locked, e_lk[j]);
        chk($sformatf("%s_w%0d_oor", nm, j), oor, e_oor[j]);
      end else if (e > SET && (e - SET) % WIN == WIN - 1) begin
        j = (e - SET) / WIN;
        chk($sformatf("%s_pre%0d_code", nm, j + 1), code, e_code[j]);
        chk($sformatf("%s_pre%0d_state", nm, j + 1), st, e_st[j]);
      end
    end
  endtask

  task automatic idle_chk(input string nm);
    start = 1'b0;
    pd = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_state"}, st, 0);
    chk({nm, "_idle_code"}, code, MID);
    chk({nm, "_idle_en"}, {en_pa, en_ro, en_pd}, 0);
    chk({nm, "_idle_locked"}, locked, 0);
    chk({nm, "_idle_oor"}, oor, 0);
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{"coarse_up", M_UP,   4,  15, 3, 0, 1};
    tbl[1] = '{"coarse_dn", M_DN,   5,  0,  3, 0, 1};
    tbl[2] = '{"alt_lock",  M_ALT,  11, 11, 4, 1, 0};
    tbl[3] = '{"tie_lock",  M_TIE,  11, 8,  4, 1, 0};
    tbl[4] = '{"edge_lock", M_EDGE, 11, 11, 4, 1, 0};
    tbl[5] = '{"lock_loss", M_LOSS, 13, 13, 3, 0, 0};

    rst_n = 1'b0;
    start = 1'b1;
    pd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code", code, MID);
    chk("rst_en", {en_pa, en_ro, en_pd}, 0);
    chk("rst_locked", locked, 0);
    chk("rst_oor", oor, 0);
    chk("rst_state", st, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_state", st, 1);
    chk("rel_en", {en_pa, en_ro, en_pd}, 7);
    idle_chk("post_rst");

    start = 1'b1;
    pd = 1'b1;
    for (int e = 0; e < 100; e++) @(negedge clk);
    chk("abort_pre_code", code, 12);
    chk("abort_pre_state", st, 2);
    idle_chk("abort");
    start = 1'b1;
    @(negedge clk);
    chk("restart_state0", st, 1);
    repeat (15) @(negedge clk);
    chk("restart_state15", st, 1);
    @(negedge clk);
    chk("restart_state16", st, 2);
    chk("restart_code", code, MID);
    idle_chk("restart");

    for (int t = 0; t < 6; t++) begin
      run(tbl[t].name, tbl[t].mode, tbl[t].nwin);
      chk({tbl[t].name, "_fin_code"}, code, tbl[t].code);
      chk({tbl[t].name, "_fin_state"}, st, tbl[t].st);
      chk({tbl[t].name, "_fin_locked"}, locked, tbl[t].lk);
      chk({tbl[t].name, "_fin_oor"}, oor, tbl[t].oor);
      idle_chk(tbl[t].name);
    end

    for (int r = 0; r < 6; r++) begin
      run($sformatf("rand%0d", r), M_RAND, 20);
      idle_chk($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
